// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : trap_ctrl
// Brief    : Machine-mode trap entry / mret sequencer driving the trap CSR port
// Revision : 1.0  initial release
// ============================================================================
module trap_ctrl #(
    parameter bit VECTORED_EN = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hx_valid_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] pc_n_i,
    input  logic [31:0] inst_i,
    input  logic        ecall_i,
    input  logic        ebreak_i,
    input  logic        illegal_i,
    input  logic        mret_i,
    input  logic        ex_trap_valid_i,
    input  logic        tcmp_trap_valid_i,
    input  logic        soft_trap_valid_i,
    input  logic        mstatus_MIE3_i,
    output logic        trap_csr_we_o,
    output logic [11:0] trap_csr_addr_o,
    output logic [31:0] trap_csr_wdata_o,
    input  logic [31:0] trap_csr_rdata_i,
    output logic        trap_stall_o,
    output logic        trap_jump_o,
    output logic [31:0] trap_jaddr_o
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_W_MEPC   = 3'd1;
    localparam logic [2:0] S_W_MCAUSE = 3'd2;
    localparam logic [2:0] S_W_MTVAL  = 3'd3;
    localparam logic [2:0] S_W_MSTAT  = 3'd4;
    localparam logic [2:0] S_JUMP_T   = 3'd5;
    localparam logic [2:0] S_R_MRET   = 3'd6;
    localparam logic [2:0] S_JUMP_M   = 3'd7;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam logic [31:0] CAUSE_ILLEGAL = 32'h0000_0002;
    localparam logic [31:0] CAUSE_BREAK   = 32'h0000_0003;
    localparam logic [31:0] CAUSE_ECALL   = 32'h0000_000B;
    localparam logic [31:0] CAUSE_M_SOFT  = 32'h8000_0003;
    localparam logic [31:0] CAUSE_M_TIMER = 32'h8000_0007;
    localparam logic [31:0] CAUSE_M_EXT   = 32'h8000_000B;

    logic [2:0]  state_q, state_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] tval_q, tval_d;

    logic        exc_req;
    logic        irq_req;
    logic        accept;
    logic [31:0] ev_epc;
    logic [31:0] ev_cause;
    logic [31:0] ev_tval;
    logic [31:0] tvec_base;
    logic        unused_rdata;

    assign tvec_base    = {trap_csr_rdata_i[31:2], 2'b00};
    assign unused_rdata = ^trap_csr_rdata_i[1:0];

    // Event decode: exceptions beat mret, mret beats interrupts.
    always_comb begin
        exc_req  = ecall_i | ebreak_i | illegal_i;
        irq_req  = mstatus_MIE3_i & (ex_trap_valid_i | soft_trap_valid_i | tcmp_trap_valid_i);
        accept   = hx_valid_i & (exc_req | mret_i | irq_req);
        ev_epc   = pc_i;
        ev_tval  = 32'd0;
        ev_cause = CAUSE_ECALL;
        if (illegal_i) begin
            ev_cause = CAUSE_ILLEGAL;
            ev_tval  = inst_i;
        end else if (ebreak_i) begin
            ev_cause = CAUSE_BREAK;
            ev_tval  = pc_i;
        end else if (!ecall_i) begin
            ev_epc   = pc_n_i;
            ev_cause = ex_trap_valid_i   ? CAUSE_M_EXT  :
                       soft_trap_valid_i ? CAUSE_M_SOFT : CAUSE_M_TIMER;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            epc_q   <= 32'd0;
            cause_q <= 32'd0;
            tval_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            tval_q  <= tval_d;
        end
    end

    always_comb begin
        state_d = state_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        tval_d  = tval_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!exc_req && mret_i) begin
                        state_d = S_R_MRET;
                    end else begin
                        state_d = S_W_MEPC;
                        epc_d   = ev_epc;
                        cause_d = ev_cause;
                        tval_d  = ev_tval;
                    end
                end
            end
            S_W_MEPC:   state_d = S_W_MCAUSE;
            S_W_MCAUSE: state_d = S_W_MTVAL;
            S_W_MTVAL:  state_d = S_W_MSTAT;
            S_W_MSTAT:  state_d = S_JUMP_T;
            S_JUMP_T:   state_d = S_IDLE;
            S_R_MRET:   state_d = S_JUMP_M;
            S_JUMP_M:   state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        trap_csr_we_o    = 1'b0;
        trap_csr_addr_o  = 12'd0;
        trap_csr_wdata_o = 32'd0;
        trap_jump_o      = 1'b0;
        trap_jaddr_o     = 32'd0;
        trap_stall_o     = 1'b1;
        case (state_q)
            S_IDLE: trap_stall_o = accept;
            S_W_MEPC: begin
                trap_csr_we_o    = 1'b1;
                trap_csr_addr_o  = CSR_MEPC;
                trap_csr_wdata_o = epc_q;
            end
            S_W_MCAUSE: begin
                trap_csr_we_o    = 1'b1;
                trap_csr_addr_o  = CSR_MCAUSE;
                trap_csr_wdata_o = cause_q;
            end
            S_W_MTVAL: begin
                trap_csr_we_o    = 1'b1;
                trap_csr_addr_o  = CSR_MTVAL;
                trap_csr_wdata_o = tval_q;
            end
            S_W_MSTAT: begin
                // MPIE <= MIE, MIE <= 0
                trap_csr_we_o    = 1'b1;
                trap_csr_addr_o  = CSR_MSTATUS;
                trap_csr_wdata_o = {24'd0, trap_csr_rdata_i[3], 7'd0};
            end
            S_JUMP_T: begin
                trap_csr_addr_o = CSR_MTVEC;
                trap_jump_o     = 1'b1;
                trap_jaddr_o    = (VECTORED_EN && cause_q[31]) ? tvec_base + (cause_q << 2)
                                                               : tvec_base;
            end
            S_R_MRET: begin
                // MIE <= MPIE, MPIE <= 1
                trap_csr_we_o    = 1'b1;
                trap_csr_addr_o  = CSR_MSTATUS;
                trap_csr_wdata_o = {24'd0, 1'b1, 3'd0, trap_csr_rdata_i[7], 3'd0};
            end
            S_JUMP_M: begin
                trap_csr_addr_o = CSR_MEPC;
                trap_jump_o     = 1'b1;
                trap_jaddr_o    = tvec_base;
            end
            default: trap_stall_o = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_trap_ctrl
// Brief    : Randomised bench for trap_ctrl with a schedule-based trap model
// Revision : 1.0  initial release
// ============================================================================
module tb_trap_ctrl;

    localparam bit VEC = 1'b1;

    typedef struct packed {
        logic        stall;
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        jump;
        logic [31:0] jaddr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        hx_valid, ecall, ebreak, illegal, mret;
    logic        ex_irq, tm_irq, sw_irq;
    logic [31:0] pc, pc_n, inst;
    logic        we, stall, jump;
    logic [11:0] addr;
    logic [31:0] wdata, rdata, jaddr;

    // Surrounding CSR block
    logic [31:0] env_mstatus = 32'd0, env_mepc = 32'd0, env_mcause = 32'd0;
    logic [31:0] env_mtval = 32'd0, env_mtvec = 32'd0;
    logic        pre_valid;
    logic [31:0] pre_ms, pre_tv, pre_ep;

    // Reference model state
    logic [31:0] m_mstatus = 32'd0, m_mepc = 32'd0, m_mtvec = 32'd0;
    exp_t        q[$];

    logic [43:0] wlog[$];
    int          jump_cnt = 0;
    int          last_jcyc = 0;
    logic [31:0] last_jaddr = 32'd0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    trap_ctrl #(.VECTORED_EN(VEC)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .hx_valid_i        (hx_valid),
        .pc_i              (pc),
        .pc_n_i            (pc_n),
        .inst_i            (inst),
        .ecall_i           (ecall),
        .ebreak_i          (ebreak),
        .illegal_i         (illegal),
        .mret_i            (mret),
        .ex_trap_valid_i   (ex_irq),
        .tcmp_trap_valid_i (tm_irq),
        .soft_trap_valid_i (sw_irq),
        .mstatus_MIE3_i    (env_mstatus[3]),
        .trap_csr_we_o     (we),
        .trap_csr_addr_o   (addr),
        .trap_csr_wdata_o  (wdata),
        .trap_csr_rdata_i  (rdata),
        .trap_stall_o      (stall),
        .trap_jump_o       (jump),
        .trap_jaddr_o      (jaddr)
    );

    always_comb begin
        rdata = 32'd0;
        case (addr)
            12'h300: rdata = env_mstatus;
            12'h305: rdata = env_mtvec;
            12'h341: rdata = env_mepc;
            12'h342: rdata = env_mcause;
            12'h343: rdata = env_mtval;
            default: rdata = 32'd0;
        endcase
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pre_valid) begin
            env_mstatus <= pre_ms;
            env_mtvec   <= pre_tv;
            env_mepc    <= pre_ep;
        end else if (rst_n && we) begin
            case (addr)
                12'h300: env_mstatus <= wdata;
                12'h341: env_mepc    <= wdata;
                12'h342: env_mcause  <= wdata;
                12'h343: env_mtval   <= wdata;
                default: ;
            endcase
        end
    end

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [43:0] wl(input int i);
        if (i < wlog.size()) return wlog[i];
        return '1;
    endfunction

    // A trap is a fixed five-cycle script computed entirely at detection time.
    function automatic void push_trap(input logic [31:0] epc, input logic [31:0] cause,
                                      input logic [31:0] tval);
        exp_t        e;
        logic [31:0] base;
        e = '0; e.stall = 1'b1; e.we = 1'b1;
        e.addr = 12'h341; e.wdata = epc;   q.push_back(e);
        e.addr = 12'h342; e.wdata = cause; q.push_back(e);
        e.addr = 12'h343; e.wdata = tval;  q.push_back(e);
        e.addr = 12'h300; e.wdata = m_mstatus[3] ? 32'h80 : 32'h0; q.push_back(e);
        base = m_mtvec & 32'hFFFF_FFFC;
        e = '0; e.stall = 1'b1; e.addr = 12'h305; e.jump = 1'b1;
        e.jaddr = (VEC && cause[31]) ? base + 4 * (cause & 32'h7FFF_FFFF) : base;
        q.push_back(e);
    endfunction

    function automatic void push_mret();
        exp_t e;
        e = '0; e.stall = 1'b1; e.we = 1'b1; e.addr = 12'h300;
        e.wdata = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
        q.push_back(e);
        e = '0; e.stall = 1'b1; e.addr = 12'h341; e.jump = 1'b1;
        e.jaddr = m_mepc & 32'hFFFF_FFFC;
        q.push_back(e);
    endfunction

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete();
                continue;
            end
            if (q.size() != 0) begin
                e = q.pop_front();
            end else begin
                e = '0;
                if (hx_valid) begin
                    if (illegal)     push_trap(pc, 32'd2, inst);
                    else if (ebreak) push_trap(pc, 32'd3, pc);
                    else if (ecall)  push_trap(pc, 32'd11, 32'd0);
                    else if (mret)   push_mret();
                    else if (m_mstatus[3] && (ex_irq || sw_irq || tm_irq))
                        push_trap(pc_n, ex_irq ? 32'h8000_000B :
                                        sw_irq ? 32'h8000_0003 : 32'h8000_0007, 32'd0);
                    e.stall = (q.size() != 0);
                end
            end
            check("cycle_outputs", {stall, we, addr, wdata, jump, jaddr}, e);
            if (we) wlog.push_back({addr, wdata});
            if (jump) begin
                jump_cnt++;
                last_jcyc  = cyc;
                last_jaddr = jaddr;
            end
            if (e.we) begin
                if (e.addr == 12'h300) m_mstatus = e.wdata;
                if (e.addr == 12'h341) m_mepc    = e.wdata;
            end
            if (pre_valid) begin
                m_mstatus = pre_ms;
                m_mtvec   = pre_tv;
                m_mepc    = pre_ep;
            end
        end
    endtask

    task automatic idle_inputs();
        hx_valid = 1'b0; ecall = 1'b0; ebreak = 1'b0; illegal = 1'b0; mret = 1'b0;
        pc = 32'd0; pc_n = 32'd0; inst = 32'd0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (q.size() != 0) check("idle_wait", q.size(), 0);
    endtask

    task automatic preload(input logic [31:0] ms, input logic [31:0] tv, input logic [31:0] ep);
        wait_idle();
        idle_inputs();
        pre_ms = ms; pre_tv = tv; pre_ep = ep; pre_valid = 1'b1;
        @(posedge clk); #1;
        pre_valid = 1'b0;
    endtask

    task automatic retire(input logic [31:0] p, input logic [31:0] pn, input logic [31:0] in,
                          input logic ec, input logic eb, input logic il, input logic mr,
                          output int det, output logic st);
        wait_idle();
        det = cyc;
        hx_valid = 1'b1; pc = p; pc_n = pn; inst = in;
        ecall = ec; ebreak = eb; illegal = il; mret = mr;
        #1 st = stall;
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic wait_jump(input int js);
        int n = 0;
        while (jump_cnt == js && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("jump_seen", jump_cnt > js, 1);
    endtask

    initial begin
        int   ws, js, det;
        logic st;
        rst_n = 1'b0;
        pre_valid = 1'b0; pre_ms = 32'd0; pre_tv = 32'd0; pre_ep = 32'd0;
        ex_irq = 1'b0; sw_irq = 1'b0; tm_irq = 1'b0;
        idle_inputs();
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {stall, we, addr, wdata, jump, jaddr}, 0);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("idle_we_stall", {we, stall}, 0);

        // ecall, non-interrupt cause jumps to the base
        preload(32'h88, 32'h200, 32'h0);
        ws = wlog.size(); js = jump_cnt;
        retire(32'h100, 32'h104, 32'h73, 1'b1, 1'b0, 1'b0, 1'b0, det, st);
        check("ecall_stall", st, 1);
        wait_jump(js);
        check("ecall_mepc",    wl(ws),     {12'h341, 32'h100});
        check("ecall_mcause",  wl(ws + 1), {12'h342, 32'd11});
        check("ecall_mtval",   wl(ws + 2), {12'h343, 32'd0});
        check("ecall_mstatus", wl(ws + 3), {12'h300, 32'h80});
        check("ecall_jaddr",   last_jaddr, 32'h200);
        check("ecall_latency", last_jcyc - det, 5);

        // timer interrupt, vectored
        preload(32'h08, 32'h201, 32'h0);
        tm_irq = 1'b1;
        ws = wlog.size(); js = jump_cnt;
        retire(32'h40, 32'h44, 32'h13, 1'b0, 1'b0, 1'b0, 1'b0, det, st);
        tm_irq = 1'b0;
        wait_jump(js);
        check("tmr_mepc",   wl(ws),     {12'h341, 32'h44});
        check("tmr_mcause", wl(ws + 1), {12'h342, 32'h8000_0007});
        check("tmr_jaddr",  last_jaddr, 32'h21C);

        // illegal with every interrupt pending
        preload(32'h88, 32'h300, 32'h0);
        ex_irq = 1'b1; sw_irq = 1'b1; tm_irq = 1'b1;
        ws = wlog.size(); js = jump_cnt;
        retire(32'h200, 32'h204, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, det, st);
        wait_jump(js);
        check("ill_mcause",  wl(ws + 1), {12'h342, 32'd2});
        check("ill_mtval",   wl(ws + 2), {12'h343, 32'hFFFF_FFFF});
        check("ill_mstatus", wl(ws + 3), {12'h300, 32'h80});
        check("ill_jaddr",   last_jaddr, 32'h300);
        retire(32'h300, 32'h304, 32'h13, 1'b0, 1'b0, 1'b0, 1'b0, det, st);
        check("no_irq_mie0", st, 0);
        sw_irq = 1'b0; tm_irq = 1'b0;

        // mret with external interrupt still pending
        preload(32'h80, 32'h300, 32'h104);
        ws = wlog.size(); js = jump_cnt;
        retire(32'h400, 32'h404, 32'h3020_0073, 1'b0, 1'b0, 1'b0, 1'b1, det, st);
        check("mret_stall", st, 1);
        wait_jump(js);
        check("mret_mstatus", wl(ws), {12'h300, 32'h88});
        check("mret_jaddr",   last_jaddr, 32'h104);
        check("mret_latency", last_jcyc - det, 2);
        ws = wlog.size(); js = jump_cnt;
        retire(32'h104, 32'h108, 32'h13, 1'b0, 1'b0, 1'b0, 1'b0, det, st);
        check("ext_taken", st, 1);
        wait_jump(js);
        check("ext_mepc",   wl(ws),     {12'h341, 32'h108});
        check("ext_mcause", wl(ws + 1), {12'h342, 32'h8000_000B});
        check("ext_jaddr",  last_jaddr, 32'h32C);
        ex_irq = 1'b0;

        // reset pulse during the mcause write
        preload(32'h88, 32'h200, 32'h0);
        retire(32'h500, 32'h504, 32'h73, 1'b1, 1'b0, 1'b0, 1'b0, det, st);
        @(posedge clk); #1;
        check("in_mcause", {we, addr}, {1'b1, 12'h342});
        rst_n = 1'b0;
        #1;
        check("rst_async_drop", {stall, we, jump}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mepc_kept",      env_mepc,   32'h500);
        check("rst_mcause_unwritten", env_mcause, 32'h8000_000B);

        // randomised traffic
        for (int i = 0; i < 2000; i++) begin
            if (q.size() == 0 && $urandom_range(0, 15) == 0) begin
                preload($urandom, $urandom, $urandom);
            end else begin
                hx_valid = ($urandom_range(0, 1) == 1);
                ecall    = ($urandom_range(0, 9) == 0);
                ebreak   = ($urandom_range(0, 9) == 0);
                illegal  = ($urandom_range(0, 9) == 0);
                mret     = ($urandom_range(0, 5) == 0);
                ex_irq   = ($urandom_range(0, 5) == 0);
                sw_irq   = ($urandom_range(0, 5) == 0);
                tm_irq   = ($urandom_range(0, 5) == 0);
                pc       = $urandom & 32'hFFFF_FFFC;
                pc_n     = pc + 32'd4;
                inst     = $urandom;
                @(posedge clk); #1;
            end
        end
        idle_inputs();
        ex_irq = 1'b0; sw_irq = 1'b0; tm_irq = 1'b0;
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
